// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write arbiter: FSM states and the beat counter width.
package fifo_arb_pkg;
  typedef enum logic {ARB_IDLE = 1'b0, ARB_OWN = 1'b1} arb_state_e;
  localparam int WR_COUNT_W = 16;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req scanning upward from ptr, with wrap.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         valid
);
  int j;
  logic [W-1:0] j_w;

  // Scan from the farthest offset down so the closest requester to ptr wins last.
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    j      = 0;
    j_w    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      j_w = W'(j);
      if (req[j_w]) begin
        onehot      = '0;
        onehot[j_w] = 1'b1;
        idx         = j_w;
        valid       = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Define FIFO_ARB_BURST_EN to let a winner keep the port for up to MAX_BURST beats.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        fifo_en,
  output logic                        fifo_wr,
  output logic [DATA_W-1:0]           fifo_din,
  input  logic                        fifo_full,
  output logic [WR_COUNT_W-1:0]       wr_count
);
  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BURST);
`ifdef FIFO_ARB_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  arb_state_e          state, state_n;
  logic [ID_W-1:0]     owner, owner_n;
  logic [ID_W-1:0]     rr_ptr, ptr_n;
  logic [BEAT_W-1:0]   beats, beats_n;
  logic [NUM_REQ-1:0]  cand, pick_oh;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_vld;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] x);
    return (x == ID_W'(NUM_REQ - 1)) ? '0 : x + 1'b1;
  endfunction

  // While a burst is owned, only the owner may compete.
  always_comb begin
    cand = req;
    if (state == ARB_OWN) cand = req & (NUM_REQ'(1) << owner);
  end

  rr_pick #(.N(NUM_REQ), .W(ID_W)) u_pick (
    .req    (cand),
    .ptr    (rr_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .valid  (pick_vld)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= ARB_IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beats    <= '0;
      fifo_en  <= 1'b0;
      grant_id <= '0;
      wr_count <= '0;
    end else begin
      state   <= state_n;
      owner   <= owner_n;
      rr_ptr  <= ptr_n;
      beats   <= beats_n;
      fifo_en <= 1'b1;
      if (fifo_wr) begin
        grant_id <= pick_idx;
        wr_count <= wr_count + 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = rr_ptr;
    beats_n = beats;
    if (fifo_wr) begin
      if (state == ARB_IDLE) begin
        if (BURST && BEAT_MAX != 1) begin
          state_n = ARB_OWN;
          owner_n = pick_idx;
          beats_n = BEAT_W'(1);
        end else begin
          ptr_n = wrap_inc(pick_idx);
        end
      end else begin
        beats_n = beats + 1'b1;
        if (beats + 1'b1 == BEAT_MAX) begin
          state_n = ARB_IDLE;
          ptr_n   = wrap_inc(owner);
          beats_n = '0;
        end
      end
    end else if (state == ARB_OWN && !req[owner] && !fifo_full) begin
      // Owner ran dry: hand the port back without waiting out the burst.
      state_n = ARB_IDLE;
      ptr_n   = wrap_inc(owner);
      beats_n = '0;
    end
  end

  always_comb begin
    gnt      = pick_oh & {NUM_REQ{pick_vld & fifo_en & !fifo_full & !Rst}};
    fifo_wr  = |gnt;
    fifo_din = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) fifo_din = fifo_din | req_data[i*DATA_W +: DATA_W];
  end
endmodule
